// File: rtl/systolic_feeder.sv
// Purpose: captures two SIZE x SIZE operand matrices and streams them as skewed west/north wavefronts, then drains and pulses done.
// Latency: the first wavefront appears two edges after start is accepted; done follows STEPS + DRAIN_CYCLES + 1 edges after the first wavefront.
// Backpressure: none; the array must consume one vector per cycle while vec_valid is high. start is only sampled in IDLE, abort cancels at the next edge.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, abort      pass request (IDLE only) / synchronous cancel
//   mat_a, mat_b      operand matrices, element (r,c) at [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
//   a_vec, b_vec      west / north edge vectors, lane 0 in the LSBs
//   vec_valid         vectors carry a wavefront step
//   busy, done        pass in flight / one-cycle end-of-pass pulse
//   step_idx          wavefront step currently presented, 0 outside streaming
module systolic_feeder #(
  parameter int SIZE         = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 2*SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_a,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_b,
  output logic [SIZE*DATA_WIDTH-1:0]      a_vec,
  output logic [SIZE*DATA_WIDTH-1:0]      b_vec,
  output logic                            vec_valid,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(2*SIZE)-1:0]       step_idx
);

  localparam int STEPS = 2*SIZE - 1;
  localparam int SW    = $clog2(2*SIZE);
  localparam int MW    = SIZE*SIZE*DATA_WIDTH;
  localparam int VW    = SIZE*DATA_WIDTH;
  localparam int DCW   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [MW-1:0]  mat_a_q, mat_b_q;
  logic [DCW-1:0] drain_q, drain_d;
  logic [VW-1:0]  a_d, b_d;
  logic [SW-1:0]  step_d;
  logic           valid_d, busy_d, done_d;
  logic           emit, last_step, drain_end, accept;

  // step_idx doubles as the wavefront counter while streaming
  assign last_step = (step_idx == SW'(STEPS - 1));
  // the drain counter runs 0..DRAIN_CYCLES, so DRAIN is left one edge after it reaches the limit
  assign drain_end = (drain_q == DCW'(DRAIN_CYCLES));
  assign accept    = (state_q == IDLE) && start && !abort;

  // state register, captured matrices and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
      drain_q   <= '0;
      a_vec     <= '0;
      b_vec     <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      a_vec     <= a_d;
      b_vec     <= b_d;
      vec_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      step_idx  <= step_d;
      if (accept) begin
        mat_a_q <= mat_a;
        mat_b_q <= mat_b;
      end
    end
  end

  // next-state logic; abort wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = abort ? IDLE : STREAM;
      STREAM:  if (abort) state_d = IDLE;
               else if (last_step) state_d = DRAIN;
      DRAIN:   if (abort || drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    int k;
    k       = 0;
    a_d     = '0;
    b_d     = '0;
    emit    = !abort && ((state_q == LOAD) || ((state_q == STREAM) && !last_step));
    step_d  = '0;
    if (emit && (state_q == STREAM)) step_d = step_idx + SW'(1);
    valid_d = emit;
    busy_d  = (state_d != IDLE);
    done_d  = !abort && (state_q == DRAIN) && drain_end;
    drain_d = (state_q == DRAIN) ? drain_q + DCW'(1) : '0;
    // lane i of step t carries element index k = t - i along the shared dimension;
    // lanes outside the diagonal band stay zero
    for (int i = 0; i < SIZE; i++) begin
      k = int'(step_d) - i;
      if (emit && (k >= 0) && (k < SIZE)) begin
        a_d[i*DATA_WIDTH +: DATA_WIDTH] = mat_a_q[(i*SIZE + k)*DATA_WIDTH +: DATA_WIDTH];
        b_d[i*DATA_WIDTH +: DATA_WIDTH] = mat_b_q[(k*SIZE + i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  typedef logic [15:0] mat_t [4][4];
  typedef struct {
    int          cyc;
    logic [63:0] a;
    logic [63:0] b;
    int          t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start2, abort2, start4, abort4;
  logic [63:0]  ma2, mb2;
  logic [255:0] ma4, mb4;
  logic [31:0]  a2, b2;
  logic [63:0]  a4, b4;
  logic [1:0]   st2;
  logic [2:0]   st4;
  logic         vv2, busy2, done2, vv4, busy4, done4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q2[$], q4[$];
  int   dq2[$], dq4[$];
  int   blo2 = 0, bhi2 = 0, free2 = 0;
  int   blo4 = 0, bhi4 = 0, free4 = 0;
  int   c0_2, c0_4;

  systolic_feeder #(.SIZE(2), .DATA_WIDTH(16), .DRAIN_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mat_a(ma2), .mat_b(mb2),
    .a_vec(a2), .b_vec(b2), .vec_valid(vv2), .busy(busy2), .done(done2), .step_idx(st2));

  systolic_feeder #(.SIZE(4), .DATA_WIDTH(16), .DRAIN_CYCLES(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .mat_a(ma4), .mat_b(mb4),
    .a_vec(a4), .b_vec(b4), .vec_valid(vv4), .busy(busy4), .done(done4), .step_idx(st4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  function automatic logic [255:0] pack(input mat_t m, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        r[(i*n + j)*16 +: 16] = m[i][j];
    return r;
  endfunction

  // Reference wavefront: lane i at step t holds A(i, t-i) for the west edge
  // and B(t-i, i) for the north edge, zero when t-i is outside the matrix.
  function automatic logic [63:0] exp_vec(input mat_t m, input int n, input int t, input bit is_a);
    logic [63:0] v;
    int k;
    v = '0;
    for (int i = 0; i < n; i++) begin
      k = t - i;
      if (k >= 0 && k < n) v[i*16 +: 16] = is_a ? m[i][k] : m[k][i];
    end
    return v;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = 16'($urandom);
    return m;
  endfunction

  // Issue a start; the expected pass is queued only if the reference says the DUT is idle.
  task automatic go2(input mat_t A, input mat_t B);
    logic [255:0] tmp;
    exp_t e;
    tmp = pack(A, 2); ma2 = tmp[63:0];
    tmp = pack(B, 2); mb2 = tmp[63:0];
    start2 = 1'b1;
    if (cyc >= free2) begin
      c0_2 = cyc + 1;
      for (int t = 0; t < 3; t++) begin
        e.cyc = c0_2 + 1 + t; e.a = exp_vec(A, 2, t, 1); e.b = exp_vec(B, 2, t, 0); e.t = t;
        q2.push_back(e);
      end
      dq2.push_back(c0_2 + 9);
      blo2 = c0_2; bhi2 = c0_2 + 9; free2 = c0_2 + 9;
    end
    tick();
    start2 = 1'b0;
  endtask

  task automatic go4(input mat_t A, input mat_t B);
    exp_t e;
    ma4 = pack(A, 4);
    mb4 = pack(B, 4);
    start4 = 1'b1;
    if (cyc >= free4) begin
      c0_4 = cyc + 1;
      for (int t = 0; t < 7; t++) begin
        e.cyc = c0_4 + 1 + t; e.a = exp_vec(A, 4, t, 1); e.b = exp_vec(B, 4, t, 0); e.t = t;
        q4.push_back(e);
      end
      dq4.push_back(c0_4 + 9);
      blo4 = c0_4; bhi4 = c0_4 + 9; free4 = c0_4 + 9;
    end
    tick();
    start4 = 1'b0;
  endtask

  // abort takes effect at the next edge: everything due after this cycle is cancelled
  task automatic do_abort4();
    int n;
    n = cyc;
    abort4 = 1'b1;
    while (q4.size() > 0 && q4[$].cyc > n) void'(q4.pop_back());
    while (dq4.size() > 0 && dq4[$] > n) void'(dq4.pop_back());
    if (bhi4 > n + 1) bhi4 = n + 1;
    if (free4 > n + 1) free4 = n + 1;
    tick();
    abort4 = 1'b0;
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    while (q2.size() > 0 && q2[0].cyc < cyc) begin
      e = q2.pop_front();
      chk("missing_step2", 64'(e.cyc), 64'(cyc));
    end
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      e = q2.pop_front();
      chk("valid2", 64'(vv2), 64'd1);
      chk("a_vec2", 64'(a2), e.a);
      chk("b_vec2", 64'(b2), e.b);
      chk("step2", 64'(st2), 64'(e.t));
    end else begin
      chk("valid2", 64'(vv2), 64'd0);
      chk("zero2", {a2, b2}, 64'd0);
      chk("step2_zero", 64'(st2), 64'd0);
    end
    if (dq2.size() > 0 && dq2[0] == cyc) begin
      void'(dq2.pop_front());
      chk("done2", 64'(done2), 64'd1);
    end else chk("done2", 64'(done2), 64'd0);
    chk("busy2", 64'(busy2), 64'(cyc >= blo2 && cyc < bhi2));
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    while (q4.size() > 0 && q4[0].cyc < cyc) begin
      e = q4.pop_front();
      chk("missing_step4", 64'(e.cyc), 64'(cyc));
    end
    if (q4.size() > 0 && q4[0].cyc == cyc) begin
      e = q4.pop_front();
      chk("valid4", 64'(vv4), 64'd1);
      chk("a_vec4", a4, e.a);
      chk("b_vec4", b4, e.b);
      chk("step4", 64'(st4), 64'(e.t));
    end else begin
      chk("valid4", 64'(vv4), 64'd0);
      chk("zero_a4", a4, 64'd0);
      chk("zero_b4", b4, 64'd0);
      chk("step4_zero", 64'(st4), 64'd0);
    end
    if (dq4.size() > 0 && dq4[0] == cyc) begin
      void'(dq4.pop_front());
      chk("done4", 64'(done4), 64'd1);
    end else chk("done4", 64'(done4), 64'd0);
    chk("busy4", 64'(busy4), 64'(cyc >= blo4 && cyc < bhi4));
  end

  initial begin
    mat_t A, B, F;
    int n, budget;
    rst = 1'b0; start2 = 1'b0; abort2 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    ma2 = '0; mb2 = '0; ma4 = '0; mb4 = '0;
    repeat (3) tick();
    chk("rst_busy", {62'd0, busy2, busy4}, 64'd0);
    chk("rst_done", {62'd0, done2, done4}, 64'd0);
    rst = 1'b1;
    tick();

    // basic skew with fixed expected vectors
    A = '{default: '{default: 16'h0}}; B = A;
    A[0][0] = 16'd1; A[0][1] = 16'd2; A[1][0] = 16'd3; A[1][1] = 16'd4;
    B[0][0] = 16'd5; B[0][1] = 16'd6; B[1][0] = 16'd7; B[1][1] = 16'd8;
    go2(A, B);
    n = q2.size();
    q2[n-3].a = 64'h0000_0001; q2[n-3].b = 64'h0000_0005;
    q2[n-2].a = 64'h0003_0002; q2[n-2].b = 64'h0006_0007;
    q2[n-1].a = 64'h0004_0000; q2[n-1].b = 64'h0008_0000;
    wait_until(free2);

    // back-to-back start during the done cycle, then a start while busy that must be ignored
    go2(rnd_mat(), rnd_mat());
    wait_until(c0_2 + 2);
    go2(rnd_mat(), rnd_mat());
    wait_until(free2 + 3);

    // asynchronous reset while draining
    go2(rnd_mat(), rnd_mat());
    wait_until(c0_2 + 5);
    rst = 1'b0;
    while (q2.size() > 0 && q2[$].cyc >= cyc) void'(q2.pop_back());
    while (dq2.size() > 0 && dq2[$] >= cyc) void'(dq2.pop_back());
    if (bhi2 > cyc) bhi2 = cyc;
    free2 = cyc;
    #1;
    chk("arst_vec", {a2, b2}, 64'd0);
    chk("arst_ctl", {60'd0, vv2, busy2, done2, 1'b0}, 64'd0);
    chk("arst_step", 64'(st2), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    go2(rnd_mat(), rnd_mat());
    wait_until(free2 + 1);

    // abort at step 1, quiet window, then a full pass
    go4(rnd_mat(), rnd_mat());
    wait_until(c0_4 + 2);
    do_abort4();
    repeat (20) tick();
    go4(rnd_mat(), rnd_mat());
    wait_until(free4);

    // all-ones extremes, back-to-back
    F = '{default: '{default: 16'hFFFF}};
    go4(F, F);
    wait_until(free4);
    go4(F, rnd_mat());
    wait_until(free4);

    // randomized passes with random gaps and occasional aborts
    for (int i = 0; i < 12; i++) begin
      go4(rnd_mat(), rnd_mat());
      if ($urandom_range(0, 3) == 0) begin
        wait_until(c0_4 + $urandom_range(0, 10));
        do_abort4();
      end
      if ($urandom_range(0, 1) == 1) go2(rnd_mat(), rnd_mat());
      wait_until(free4 + $urandom_range(0, 2));
    end

    budget = 0;
    while ((q2.size() + q4.size() + dq2.size() + dq4.size()) > 0 && budget < 200) begin
      tick();
      budget++;
    end
    if ((q2.size() + q4.size() + dq2.size() + dq4.size()) > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", q2.size() + q4.size() + dq2.size() + dq4.size());
    end
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
